// File: rtl/booth_pkg.sv
// Shared types and Booth recoding helper for the radix-4 signed multiplier.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        PP_ZERO,
        PP_POS1,
        PP_POS2,
        PP_NEG1,
        PP_NEG2
    } pp_sel_t;

    // Bits are {q[1], q[0], q_m1}.
    function automatic pp_sel_t booth_recode(input logic [2:0] bits);
        pp_sel_t sel;
        case (bits)
            3'b001, 3'b010: sel = PP_POS1;
            3'b011:         sel = PP_POS2;
            3'b100:         sel = PP_NEG2;
            3'b101, 3'b110: sel = PP_NEG1;
            default:        sel = PP_ZERO;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// Combinational partial-product generator: selects 0, +-M or +-2M at WIDTH+2 bits.
module booth_pp_gen
    import booth_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] mcand,
    input  pp_sel_t          sel,
    output logic [WIDTH+1:0] pp
);

    logic [WIDTH+1:0] m1;
    logic [WIDTH+1:0] m2;

    assign m1 = {{2{mcand[WIDTH-1]}}, mcand};
    assign m2 = {m1[WIDTH:0], 1'b0};

    always_comb begin
        pp = '0;
        case (sel)
            PP_POS1: pp = m1;
            PP_POS2: pp = m2;
            PP_NEG1: pp = -m1;
            PP_NEG2: pp = -m2;
            default: pp = '0;
        endcase
    end

endmodule

// File: rtl/booth_mul_ctrl.sv
// Radix-4 Booth multiplier sequencer: operand handshake, WIDTH/2 add-and-shift
// steps over the {acc, q, q_m1} register, then a product handshake.
module booth_mul_ctrl
    import booth_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int STEPS = WIDTH / 2;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    state_t           state;
    state_t           state_n;
    logic [WIDTH+1:0] acc;
    logic [WIDTH-1:0] q;
    logic             q_m1;
    logic [WIDTH-1:0] mcand;
    logic [CW-1:0]    cnt;
    logic             rdy_q;
    logic             accept;
    logic             last_step;
    pp_sel_t          sel;
    logic [WIDTH+1:0] pp;
    logic [WIDTH+1:0] sum;

    booth_pp_gen #(
        .WIDTH (WIDTH)
    ) u_pp_gen (
        .mcand (mcand),
        .sel   (sel),
        .pp    (pp)
    );

    assign sel       = booth_recode({q[1:0], q_m1});
    assign sum       = acc + pp;
    assign last_step = (cnt == CW'(STEPS - 1));

    // rdy_q keeps in_ready low during reset without a combinational path from rst.
    assign in_ready  = (state == IDLE) && rdy_q;
    assign accept    = in_ready && in_valid;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign product   = {acc[WIDTH-1:0], q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            rdy_q <= 1'b0;
        end else begin
            state <= state_n;
            rdy_q <= 1'b1;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept)    state_n = CALC;
            CALC:    if (last_step) state_n = DONE;
            DONE:    if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            q     <= '0;
            q_m1  <= 1'b0;
            mcand <= '0;
            cnt   <= '0;
        end else if (accept) begin
            mcand <= multiplicand;
            q     <= multiplier;
            acc   <= '0;
            q_m1  <= 1'b0;
            cnt   <= '0;
        end else if (state == CALC) begin
            q_m1 <= q[1];
            q    <= {sum[1:0], q[WIDTH-1:2]};
            acc  <= {sum[WIDTH+1], sum[WIDTH+1], sum[WIDTH+1:2]};
            cnt  <= cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_booth_mul_ctrl.sv
// Self-checking bench for booth_mul_ctrl against a signed-arithmetic reference.
module tb_booth_mul_ctrl;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   multiplicand;
    logic [W-1:0]   multiplier;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] product;
    logic           busy;

    int errors = 0;
    int checks = 0;

    booth_mul_ctrl #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .product      (product),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 64'(sa * sb);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one full transaction; reports the product seen while out_valid,
    // cycles from accept edge to out_valid, and whether any wait expired.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [2*W-1:0] p, output int lat, output bit timed_out);
        int guard;
        timed_out = 1'b0;
        p = '0;
        lat = 0;
        multiplicand = a;
        multiplier = b;
        in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 100) begin
            tick();
            guard++;
        end
        if (!in_ready) begin
            timed_out = 1'b1;
            in_valid = 1'b0;
            return;
        end
        tick();
        in_valid = 1'b0;
        multiplicand = $urandom;
        multiplier = $urandom;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        if (!out_valid) begin
            timed_out = 1'b1;
            return;
        end
        p = product;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        multiplicand = '0;
        multiplier = '0;
        #1;
        checks++;
        if ({in_ready, out_valid, busy} !== 3'b000 || product !== '0) begin
            errors++;
            $display("FAIL reset_hold: in_ready=%b out_valid=%b busy=%b product=%h required 0 0 0 0",
                     in_ready, out_valid, busy, product);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if ({in_ready, out_valid, busy} !== 3'b100 || product !== '0) begin
            errors++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b busy=%b product=%h required 1 0 0 0",
                     in_ready, out_valid, busy, product);
        end
    endtask

    task automatic test_basic();
        logic [2*W-1:0] p;
        int lat;
        bit to;
        do_op(32'd3, 32'd5, p, lat, to);
        checks++;
        if (to || p !== 64'h0000_0000_0000_000F) begin
            errors++;
            $display("FAIL basic_3x5: product=%h timeout=%0b required %h", p, to, 64'hF);
        end
        checks++;
        if (lat !== 16) begin
            errors++;
            $display("FAIL basic_latency: cycles=%0d required 16", lat);
        end
    endtask

    task automatic test_mixed_sign();
        logic [2*W-1:0] p;
        int lat;
        bit to;
        do_op(-32'sd7, 32'd9, p, lat, to);
        checks++;
        if (to || p !== 64'hFFFF_FFFF_FFFF_FFC1) begin
            errors++;
            $display("FAIL mixed_m7x9: product=%h timeout=%0b required %h", p, to, 64'hFFFF_FFFF_FFFF_FFC1);
        end
    endtask

    task automatic test_extremes();
        logic [W-1:0]   a_tab [4] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'hFFFF_FFFF};
        logic [W-1:0]   b_tab [4] = '{32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF};
        logic [2*W-1:0] e_tab [4] = '{64'h4000_0000_0000_0000, 64'hC000_0000_8000_0000,
                                      64'h3FFF_FFFF_0000_0001, 64'h0000_0000_0000_0001};
        logic [2*W-1:0] p;
        int lat;
        bit to;
        for (int i = 0; i < 4; i++) begin
            do_op(a_tab[i], b_tab[i], p, lat, to);
            checks++;
            if (to || p !== e_tab[i] || p !== ref_mul(a_tab[i], b_tab[i])) begin
                errors++;
                $display("FAIL extreme_%0d: %h x %h product=%h required %h", i, a_tab[i], b_tab[i], p, e_tab[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] held;
        logic [2*W-1:0] p;
        int lat;
        int guard;
        bit to;
        a = $urandom;
        b = $urandom;
        multiplicand = a;
        multiplier = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        guard = 0;
        while (!out_valid && guard < 100) begin
            tick();
            guard++;
        end
        held = product;
        checks++;
        if (!out_valid || held !== ref_mul(a, b)) begin
            errors++;
            $display("FAIL bp_product: out_valid=%b product=%h required %h", out_valid, held, ref_mul(a, b));
        end
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0] ? 1'b0 : 1'b1;
            multiplicand = $urandom;
            multiplier = $urandom;
            tick();
            checks++;
            if (product !== held || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold_%0d: product=%h in_ready=%b out_valid=%b required %h 0 1",
                         i, product, in_ready, out_valid, held);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || product !== held) begin
            errors++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b product=%h required 0 1 %h",
                     out_valid, in_ready, product, held);
        end
        a = $urandom;
        b = $urandom;
        do_op(a, b, p, lat, to);
        checks++;
        if (to || p !== ref_mul(a, b)) begin
            errors++;
            $display("FAIL bp_next: product=%h required %h", p, ref_mul(a, b));
        end
    endtask

    task automatic test_reset_mid();
        logic [2*W-1:0] p;
        int lat;
        bit to;
        bit seen;
        multiplicand = 32'h1234_5678;
        multiplier = 32'h9ABC_DEF0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        rst = 1'b1;
        #1;
        checks++;
        if ({in_ready, out_valid, busy} !== 3'b000 || product !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: in_ready=%b out_valid=%b busy=%b product=%h required 0 0 0 0",
                     in_ready, out_valid, busy, product);
        end
        tick();
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL midreset_no_valid: out_valid observed=1 required 0");
        end
        do_op(32'd2, -32'sd3, p, lat, to);
        checks++;
        if (to || p !== 64'hFFFF_FFFF_FFFF_FFFA) begin
            errors++;
            $display("FAIL midreset_2xm3: product=%h required %h", p, 64'hFFFF_FFFF_FFFF_FFFA);
        end
    endtask

    task automatic test_back_to_back();
        logic [2*W-1:0] expq[$];
        int done_cnt;
        int cyc;
        int last_acc;
        bit first;
        done_cnt = 0;
        cyc = 0;
        last_acc = 0;
        first = 1'b1;
        multiplicand = $urandom;
        multiplier = $urandom;
        in_valid = 1'b1;
        while (done_cnt < 1000 && cyc < 40000) begin
            out_ready = $urandom_range(0, 1) == 1;
            if (in_valid && in_ready) begin
                expq.push_back(ref_mul(multiplicand, multiplier));
                if (!first) begin
                    checks++;
                    if (cyc - last_acc < 18) begin
                        errors++;
                        $display("FAIL b2b_spacing: interval=%0d required >=18", cyc - last_acc);
                    end
                end
                first = 1'b0;
                last_acc = cyc;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_spurious: product=%h with no pending operation", product);
                end else begin
                    if (product !== expq[0]) begin
                        errors++;
                        $display("FAIL b2b_product_%0d: product=%h required %h", done_cnt, product, expq[0]);
                    end
                    void'(expq.pop_front());
                end
                done_cnt++;
            end
            tick();
            cyc++;
            if (in_ready === 1'b0 && busy) begin
                multiplicand = $urandom;
                multiplier = $urandom;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (done_cnt != 1000) begin
            errors++;
            $display("FAIL b2b_timeout: completed=%0d required 1000", done_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mixed_sign();
        test_extremes();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
